// File: rtl/ym_write_arbiter.sv
// Round-robin host bus controller for the YM2151 register file: two requesters,
// each request is an address write then a data write, followed by a busy wait and status polling.
module ym_write_arbiter #(
  parameter int BUSY_CYCLES = 2,
  parameter int POLL_MAX    = 16
) (
  input  logic       phiM,
  input  logic       IC,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       CS_b,
  output logic       WR_b,
  output logic       RD_b,
  output logic       A0,
  output logic [7:0] bus_out,
  input  logic [7:0] bus_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WAIT, S_POLL_RD, S_POLL_CHK, S_DONE
  } state_t;

  localparam int PCNT_W = $clog2(POLL_MAX + 1);
  localparam int WCNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_MAX);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((BUSY_CYCLES > 0) ? BUSY_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [PCNT_W-1:0]   poll_q, poll_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                id_q, id_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                gnt_id;
  logic                err_d, err_q;
  logic                cs_d, cs_q, wr_d, wr_q, rd_d, rd_q, a0_d, a0_q;
  logic [7:0]          bus_d, bus_q;
  logic                ack0_d, ack0_q, ack1_d, ack1_q;
  logic                unused_status;

  // Only the busy flag of the status byte matters.
  assign unused_status = ^bus_in[6:0];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    poll_d  = poll_q;
    wait_d  = wait_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_id  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // last_q holds the id served most recently; a tie goes to the other one.
          gnt_id  = (req0 && req1) ? ~last_q : req1;
          id_d    = gnt_id;
          addr_d  = gnt_id ? addr1 : addr0;
          data_d  = gnt_id ? data1 : data0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        wait_d  = '0;
        state_d = (BUSY_CYCLES == 0) ? S_POLL_RD : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_POLL_RD;
        else                     wait_d  = wait_q + 1'b1;
      end
      S_POLL_RD: begin
        poll_d  = poll_q + 1'b1;
        state_d = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (!bus_in[7]) begin
          state_d = S_DONE;
        end else if (poll_q >= POLL_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_DONE: begin
        poll_d  = '0;
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    cs_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    a0_d   = 1'b0;
    bus_d  = bus_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    case (state_d)
      S_ADDR: begin
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        bus_d = addr_d;
      end
      S_DATA: begin
        cs_d  = 1'b0;
        wr_d  = 1'b0;
        a0_d  = 1'b1;
        bus_d = data_q;
      end
      S_POLL_RD: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
      end
      S_DONE: begin
        ack0_d = ~id_q;
        ack1_d = id_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phiM) begin
    if (IC) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      poll_q  <= '0;
      wait_q  <= '0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      a0_q    <= 1'b0;
      bus_q   <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      poll_q  <= poll_d;
      wait_q  <= wait_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      a0_q    <= a0_d;
      bus_q   <= bus_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge phiM) begin
    id_q   <= id_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign CS_b    = cs_q;
  assign WR_b    = wr_q;
  assign RD_b    = rd_q;
  assign A0      = a0_q;
  assign bus_out = bus_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ym_write_arbiter.sv
// Scoreboard bench for ym_write_arbiter: two instances (B=2/POLL_MAX=4 and B=0/POLL_MAX=3)
// driven with directed and random requests against a transaction-level timing model.
module tb_ym_write_arbiter;

  localparam int B0 = 2;
  localparam int PM0 = 4;
  localparam int B1 = 0;
  localparam int PM1 = 3;
  localparam int WAIT_LIMIT = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ic_s [2];
  logic       req0_s [2];
  logic       req1_s [2];
  logic [7:0] addr0_s [2];
  logic [7:0] addr1_s [2];
  logic [7:0] data0_s [2];
  logic [7:0] data1_s [2];
  logic       ack0_s [2];
  logic       ack1_s [2];
  logic       err_s [2];
  logic       cs_s [2];
  logic       wr_s [2];
  logic       rd_s [2];
  logic       a0_s [2];
  logic [7:0] bus_out_s [2];
  logic [7:0] bus_in_s [2];

  ym_write_arbiter #(.BUSY_CYCLES(B0), .POLL_MAX(PM0)) u_dut0 (
    .phiM(clk), .IC(ic_s[0]), .req0(req0_s[0]), .req1(req1_s[0]),
    .addr0(addr0_s[0]), .addr1(addr1_s[0]), .data0(data0_s[0]), .data1(data1_s[0]),
    .ack0(ack0_s[0]), .ack1(ack1_s[0]), .err(err_s[0]),
    .CS_b(cs_s[0]), .WR_b(wr_s[0]), .RD_b(rd_s[0]), .A0(a0_s[0]),
    .bus_out(bus_out_s[0]), .bus_in(bus_in_s[0])
  );

  ym_write_arbiter #(.BUSY_CYCLES(B1), .POLL_MAX(PM1)) u_dut1 (
    .phiM(clk), .IC(ic_s[1]), .req0(req0_s[1]), .req1(req1_s[1]),
    .addr0(addr0_s[1]), .addr1(addr1_s[1]), .data0(data0_s[1]), .data1(data1_s[1]),
    .ack0(ack0_s[1]), .ack1(ack1_s[1]), .err(err_s[1]),
    .CS_b(cs_s[1]), .WR_b(wr_s[1]), .RD_b(rd_s[1]), .A0(a0_s[1]),
    .bus_out(bus_out_s[1]), .bus_in(bus_in_s[1])
  );

  typedef struct {
    int inst;
    int id;
    int addr;
    int data;
    int err;
    int start;
    int polls;
    int ack;
  } exp_t;

  exp_t sb_q[$];
  int   chip_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_srv [2];
  int   mon_addr [2];
  int   mon_data [2];
  int   mon_acyc [2];
  int   mon_dcyc [2];
  int   mon_wr [2];
  int   mon_polls [2];
  int   busy_cur [2];
  int   polls_seen [2];
  logic [7:0] chip_addr [2];
  logic [7:0] chip_reg [2][256];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Chip model: registered status read; busy for a preset number of polls after each data write.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!cs_s[k] && !wr_s[k] && !a0_s[k]) chip_addr[k] <= bus_out_s[k];
      if (!cs_s[k] && !wr_s[k] && a0_s[k]) begin
        chip_reg[k][chip_addr[k]] <= bus_out_s[k];
        if (chip_q.size() > 0) busy_cur[k] <= chip_q.pop_front();
        else                   busy_cur[k] <= 0;
        polls_seen[k] <= 0;
      end
      if (!cs_s[k] && !rd_s[k]) begin
        bus_in_s[k]   <= {(polls_seen[k] < busy_cur[k]), 7'($urandom)};
        polls_seen[k] <= polls_seen[k] + 1;
      end else begin
        bus_in_s[k] <= 8'($urandom);
      end
      if (ic_s[k]) polls_seen[k] <= 0;
    end
  end

  // Monitor: tracks bus phases and checks each ack against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ic_s[k]) begin
          mon_wr[k] = 0; mon_polls[k] = 0; mon_acyc[k] = -1; mon_dcyc[k] = -1;
        end else begin
          if (!cs_s[k] || !wr_s[k] || !rd_s[k])
            chk("strobe_combo", int'({cs_s[k], wr_s[k], rd_s[k]} == 3'b001 ||
                                     {cs_s[k], wr_s[k], rd_s[k]} == 3'b010), 1);
          if (!cs_s[k] && !wr_s[k]) begin
            mon_wr[k]++;
            if (!a0_s[k]) begin mon_addr[k] = int'(bus_out_s[k]); mon_acyc[k] = cyc; end
            else          begin mon_data[k] = int'(bus_out_s[k]); mon_dcyc[k] = cyc; end
          end
          if (!cs_s[k] && !rd_s[k]) begin
            mon_polls[k]++;
            chk("poll_a0", int'(a0_s[k]), 0);
          end
          if (ack0_s[k] || ack1_s[k]) begin
            chk("ack_onehot", int'(ack0_s[k] && ack1_s[k]), 0);
            if (sb_q.size() == 0) begin
              chk("unexpected_ack", 1, 0);
            end else begin
              mon_e = sb_q.pop_front();
              chk("ack_inst", k, mon_e.inst);
              chk("ack_id", int'(ack1_s[k]), mon_e.id);
              chk("ack_cycle", cyc, mon_e.ack);
              chk("ack_err", int'(err_s[k]), mon_e.err);
              chk("addr_value", mon_addr[k], mon_e.addr);
              chk("data_value", mon_data[k], mon_e.data);
              chk("addr_cycle", mon_acyc[k], mon_e.start + 1);
              chk("data_cycle", mon_dcyc[k], mon_e.start + 2);
              chk("poll_count", mon_polls[k], mon_e.polls);
              chk("write_strobes", mon_wr[k], 2);
            end
            mon_wr[k] = 0; mon_polls[k] = 0; mon_acyc[k] = -1; mon_dcyc[k] = -1;
          end
        end
      end
    end
  end

  task automatic do_reset(input int k);
    ic_s[k] = 1'b1; req0_s[k] = 1'b0; req1_s[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", int'(cs_s[k]), 1);
    chk("rst_wr", int'(wr_s[k]), 1);
    chk("rst_rd", int'(rd_s[k]), 1);
    chk("rst_a0", int'(a0_s[k]), 0);
    chk("rst_bus", int'(bus_out_s[k]), 0);
    chk("rst_ack", int'(ack0_s[k] | ack1_s[k]), 0);
    chk("rst_err", int'(err_s[k]), 0);
    ic_s[k] = 1'b0;
    last_srv[k] = 1;
  endtask

  // Issue one or two simultaneous requests in an idle cycle; the model
  // predicts grant order, poll count, err and ack cycle for each.
  task automatic scenario(input int k, input bit r0, input bit r1, input int bz0, input int bz1,
                          input logic [7:0] a0v, input logic [7:0] d0v,
                          input logic [7:0] a1v, input logic [7:0] d1v);
    int b, pm, t, first, n, id, bz;
    bit pend0, pend1;
    exp_t e;
    b  = (k == 0) ? B0 : B1;
    pm = (k == 0) ? PM0 : PM1;
    addr0_s[k] = a0v; data0_s[k] = d0v; addr1_s[k] = a1v; data1_s[k] = d1v;
    req0_s[k] = r0; req1_s[k] = r1;
    t = cyc;
    first = (r0 && r1) ? 1 - last_srv[k] : (r1 ? 1 : 0);
    for (int i = 0; i < 2; i++) begin
      id = (i == 0) ? first : 1 - first;
      if ((id == 0 && r0) || (id == 1 && r1)) begin
        bz = id ? bz1 : bz0;
        e.inst  = k;
        e.id    = id;
        e.addr  = int'(id ? a1v : a0v);
        e.data  = int'(id ? d1v : d0v);
        e.err   = (bz >= pm) ? 1 : 0;
        e.polls = (bz >= pm) ? pm : bz + 1;
        e.start = t;
        e.ack   = t + 3 + b + 2 * e.polls;
        sb_q.push_back(e);
        chip_q.push_back(bz);
        last_srv[k] = id;
        t = e.ack + 1;
      end
    end
    n = 0; pend0 = 1'b0; pend1 = 1'b0;
    while ((req0_s[k] || req1_s[k]) && n < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      n++;
      if (pend0) begin req0_s[k] = 1'b0; addr0_s[k] = 8'($urandom); data0_s[k] = 8'($urandom); pend0 = 1'b0; end
      if (pend1) begin req1_s[k] = 1'b0; addr1_s[k] = 8'($urandom); data1_s[k] = 8'($urandom); pend1 = 1'b0; end
      if (ack0_s[k]) pend0 = 1'b1;
      if (ack1_s[k]) pend1 = 1'b1;
    end
    if (n >= WAIT_LIMIT) begin
      chk("ack_wait_expired", n, WAIT_LIMIT - 1);
      req0_s[k] = 1'b0; req1_s[k] = 1'b0;
      sb_q.delete(); chip_q.delete();
    end
    chk("sb_drain", sb_q.size(), 0);
  endtask

  task automatic midop_reset(input int k);
    req0_s[k] = 1'b1; addr0_s[k] = 8'($urandom); data0_s[k] = 8'($urandom);
    chip_q.push_back(0);
    repeat (3) @(posedge clk);
    #1;
    ic_s[k] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs", int'(cs_s[k]), 1);
    chk("midrst_wr", int'(wr_s[k]), 1);
    chk("midrst_rd", int'(rd_s[k]), 1);
    chk("midrst_bus", int'(bus_out_s[k]), 0);
    chk("midrst_ack", int'(ack0_s[k] | ack1_s[k]), 0);
    ic_s[k] = 1'b0; req0_s[k] = 1'b0;
    last_srv[k] = 1;
    chip_q.delete();
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_rst_noack", int'(ack0_s[k] | ack1_s[k]), 0);
    end
  endtask

  task automatic random_runs(input int k, input int count);
    int r, pm;
    pm = (k == 0) ? PM0 : PM1;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(1, 3);
      scenario(k, r[0], r[1], $urandom_range(0, pm + 1), $urandom_range(0, pm + 1),
               8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ic_s[k] = 1'b1; req0_s[k] = 1'b0; req1_s[k] = 1'b0;
      addr0_s[k] = 8'h00; addr1_s[k] = 8'h00; data0_s[k] = 8'h00; data1_s[k] = 8'h00;
      mon_acyc[k] = -1; mon_dcyc[k] = -1; last_srv[k] = 1;
    end
    @(posedge clk);
    #1;
    do_reset(0);
    do_reset(1);

    scenario(0, 1'b1, 1'b1, 0, 0, 8'h20, 8'hA5, 8'h28, 8'h3C);
    scenario(0, 1'b1, 1'b0, 0, 0, 8'h1B, 8'hC0, 8'h00, 8'h00);
    chk("chip_reg_1B", int'(chip_reg[0][8'h1B]), 8'hC0);
    scenario(0, 1'b1, 1'b1, 1, 0, 8'h30, 8'h11, 8'h38, 8'h22);
    scenario(0, 1'b1, 1'b0, 3, 0, 8'h40, 8'h7F, 8'h00, 8'h00);
    scenario(0, 1'b0, 1'b1, 0, 9, 8'h00, 8'h00, 8'h60, 8'h55);
    midop_reset(0);
    scenario(0, 1'b0, 1'b1, 0, 0, 8'h00, 8'h00, 8'h08, 8'h78);
    do_reset(0);
    scenario(0, 1'b1, 1'b1, 0, 0, 8'h0F, 8'h01, 8'hF0, 8'h02);
    random_runs(0, 25);

    scenario(1, 1'b0, 1'b1, 0, 0, 8'h00, 8'h00, 8'h14, 8'h2A);
    scenario(1, 1'b1, 1'b1, 0, 5, 8'h80, 8'h81, 8'h90, 8'h91);
    random_runs(1, 20);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=%0d required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
